// File: rtl/cyl_voxel_writer_if.sv
// Purpose : bundles the voxel input bus, framebuffer BRAM port and status
//           outputs of cyl_voxel_writer into one interface.
// Ports   : slave modport = writer side (coordinates/clear/fb read data in;
//           fb address/data/we and status out); master modport = driver side.
interface cyl_voxel_writer_if #(
   parameter int ROTATIONAL_RESOLUTION = 64,
   parameter int RADIUS_BINS           = 32,
   parameter int Z_BITS                = 64
);
   localparam int TW       = $clog2(ROTATIONAL_RESOLUTION);
   localparam int FB_DEPTH = ROTATIONAL_RESOLUTION * RADIUS_BINS;
   localparam int AW       = $clog2(FB_DEPTH);

   // voxel input, pulsed, no backpressure
   logic [TW-1:0]     theta_in;
   logic [5:0]        radius_in;
   logic [5:0]        z_in;
   logic              data_valid_in;
   logic              clear_req_in;
   // framebuffer BRAM port (read-first, 2-cycle read latency)
   logic [AW-1:0]     fb_addr_out;
   logic [Z_BITS-1:0] fb_din_out;
   logic              fb_we_out;
   logic [Z_BITS-1:0] fb_dout_in;
   // status
   logic              busy_out;
   logic              clear_done_out;
   logic              overflow_out;
   logic [15:0]       drop_count_out;

   modport slave (
      input  theta_in, radius_in, z_in, data_valid_in, clear_req_in, fb_dout_in,
      output fb_addr_out, fb_din_out, fb_we_out,
      output busy_out, clear_done_out, overflow_out, drop_count_out
   );

   modport master (
      output theta_in, radius_in, z_in, data_valid_in, clear_req_in, fb_dout_in,
      input  fb_addr_out, fb_din_out, fb_we_out,
      input  busy_out, clear_done_out, overflow_out, drop_count_out
   );
endinterface

// File: rtl/cyl_voxel_writer.sv
// Purpose : buffers (theta, radius, z) voxels in a small FIFO and sets the Z bit
//           in a cylindrical framebuffer BRAM by read-modify-write; also sweeps
//           the whole framebuffer to zero on request.
// Latency : write issued 4 cycles after the input pulse (empty FIFO, IDLE);
//           one voxel per 4 cycles; clear sweep is one word per cycle.
// Backpressure: none upstream; out-of-range inputs and inputs arriving while
//           the FIFO is full are dropped and counted (overflow is sticky).
// Ports   : clk_in, rst_in (async, active-low); bus = cyl_voxel_writer_if.slave.
module cyl_voxel_writer #(
   parameter int ROTATIONAL_RESOLUTION = 64,
   parameter int RADIUS_BINS           = 32,
   parameter int Z_BITS                = 64,
   parameter int FIFO_DEPTH            = 16
) (
   input logic clk_in,
   input logic rst_in,
   cyl_voxel_writer_if.slave bus
);
   localparam int TW       = $clog2(ROTATIONAL_RESOLUTION);
   localparam int FB_DEPTH = ROTATIONAL_RESOLUTION * RADIUS_BINS;
   localparam int AW       = $clog2(FB_DEPTH);
   localparam int FW       = $clog2(FIFO_DEPTH);

   localparam logic [AW-1:0] LAST_ADDR  = AW'(FB_DEPTH - 1);
   localparam logic [6:0]    R_LIMIT    = 7'(RADIUS_BINS);
   localparam logic [6:0]    Z_LIMIT    = 7'(Z_BITS);
   localparam logic [FW:0]   FULL_COUNT = (FW + 1)'(FIFO_DEPTH);

   typedef struct packed {
      logic [TW-1:0] theta;
      logic [5:0]    radius;
      logic [5:0]    z;
   } voxel_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_W1,
      S_WR,
      S_CLEAR
   } state_t;

   state_t state_q, state_d;

   // input FIFO
   voxel_t         fifo_mem [FIFO_DEPTH];
   logic [FW-1:0]  wr_ptr, rd_ptr;
   logic [FW:0]    fifo_count;
   logic           fifo_full, fifo_empty;
   logic           in_range, push, pop, drop;

   // working register for the RMW in flight
   logic [AW-1:0]  work_addr;
   logic [5:0]     work_z;
   voxel_t         head;
   logic [AW-1:0]  head_addr;

   // clear sweep
   logic           clear_pend;
   logic [AW-1:0]  sweep_addr;
   logic           clear_start, sweep_last;
   logic           clear_done_q;

   logic           overflow_q;
   logic [15:0]    drop_count_q;

   // combinational BRAM port drive
   logic [AW-1:0]     fb_addr;
   logic [Z_BITS-1:0] fb_din;
   logic              fb_we;
   logic [Z_BITS-1:0] z_mask;

   assign fifo_full  = (fifo_count == FULL_COUNT);
   assign fifo_empty = (fifo_count == '0);

   assign in_range = ({1'b0, bus.radius_in} < R_LIMIT) && ({1'b0, bus.z_in} < Z_LIMIT);
   // fullness is judged before any same-cycle pop, so a pop never frees a slot
   // for the input arriving in that cycle
   assign push = bus.data_valid_in && in_range && !fifo_full;
   assign drop = bus.data_valid_in && (!in_range || fifo_full);

   assign head      = fifo_mem[rd_ptr];
   assign head_addr = AW'(head.theta) * AW'(RADIUS_BINS) + AW'(head.radius);

   assign z_mask = {{(Z_BITS-1){1'b0}}, 1'b1} << work_z;

   // FIFO storage carries no reset; only the pointers and count define contents
   always_ff @(posedge clk_in) begin
      if (push) begin
         fifo_mem[wr_ptr] <= '{theta: bus.theta_in, radius: bus.radius_in, z: bus.z_in};
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // FSM state register plus the datapath registers it steers
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q      <= S_IDLE;
         work_addr    <= '0;
         work_z       <= '0;
         sweep_addr   <= '0;
         clear_pend   <= 1'b0;
         clear_done_q <= 1'b0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         state_q <= state_d;

         if (pop) begin
            work_addr <= head_addr;
            work_z    <= head.z;
         end

         if (clear_start) begin
            sweep_addr <= '0;
         end else if (state_q == S_CLEAR) begin
            sweep_addr <= sweep_addr + 1'b1;
         end

         // requests while a clear is pending or sweeping are absorbed
         if (sweep_last) begin
            clear_pend <= 1'b0;
         end else if (bus.clear_req_in && state_q != S_CLEAR) begin
            clear_pend <= 1'b1;
         end

         clear_done_q <= sweep_last;

         if (bus.data_valid_in && in_range && fifo_full) begin
            overflow_q <= 1'b1;
         end

         if (drop && drop_count_q != 16'hFFFF) begin
            drop_count_q <= drop_count_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      clear_start = 1'b0;
      sweep_last  = 1'b0;
      fb_addr     = '0;
      fb_din      = '0;
      fb_we       = 1'b0;
      case (state_q)
         S_IDLE: begin
            // a pending clear wins over queued voxels; queued ones survive it
            if (clear_pend) begin
               clear_start = 1'b1;
               state_d     = S_CLEAR;
            end else if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = S_RD;
            end
         end
         S_RD: begin
            fb_addr = work_addr;
            state_d = S_W1;
         end
         S_W1: begin
            fb_addr = work_addr;
            state_d = S_WR;
         end
         S_WR: begin
            // read data for work_addr arrives exactly now (2-cycle BRAM)
            fb_addr = work_addr;
            fb_din  = bus.fb_dout_in | z_mask;
            fb_we   = 1'b1;
            state_d = S_IDLE;
         end
         S_CLEAR: begin
            fb_addr = sweep_addr;
            fb_we   = 1'b1;
            if (sweep_addr == LAST_ADDR) begin
               sweep_last = 1'b1;
               state_d    = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.fb_addr_out    = fb_addr;
   assign bus.fb_din_out     = fb_din;
   assign bus.fb_we_out      = fb_we;
   assign bus.busy_out       = !fifo_empty || (state_q != S_IDLE) || clear_pend;
   assign bus.clear_done_out = clear_done_q;
   assign bus.overflow_out   = overflow_q;
   assign bus.drop_count_out = drop_count_q;
endmodule
